// File: rtl/spi_shifter.sv
// Byte-level SPI master, mode 0, MSB first. Pops one byte from the show-ahead TX FIFO,
// shifts it out on MOSI while capturing MISO, then optionally pushes the received byte.
module spi_shifter #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tx_empty,
    input  logic [7:0]       tx_q,
    output logic             tx_rdreq,
    input  logic             rx_full,
    output logic [7:0]       rx_data,
    output logic             rx_wrreq,
    input  logic             rx_enable,
    input  logic [DIV_W-1:0] div,
    output logic             busy,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [7:0]       sr_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [3:0]       edge_q;
    logic             rx_en_q;
    logic             rx_bit_q;
    logic             sclk_q;
    logic             mosi_q;
    logic             busy_q;
    logic             rx_wrreq_q;
    logic             start;

    // The pop has to land in the same cycle the FIFO shows a byte, so it cannot be
    // registered; it is gated by reset so no byte is consumed while the FSM is held.
    assign start    = reset_n && (state_q == S_IDLE) && !tx_empty && (!rx_enable || !rx_full);
    assign tx_rdreq = start;

    assign rx_data  = sr_q;
    assign rx_wrreq = rx_wrreq_q;
    assign busy     = busy_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;

    // NOTE: every state register is assigned with <= so all of them update from the
    // same pre-edge values; a blocking assignment here would create ordering races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            sr_q       <= 8'h00;
            div_q      <= '0;
            cnt_q      <= '0;
            edge_q     <= 4'd0;
            rx_en_q    <= 1'b0;
            rx_bit_q   <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b1;
            busy_q     <= 1'b0;
            rx_wrreq_q <= 1'b0;
        end else begin
            rx_wrreq_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sr_q    <= tx_q;
                        div_q   <= div;
                        rx_en_q <= rx_enable;
                        cnt_q   <= div;
                        edge_q  <= 4'd0;
                        mosi_q  <= tx_q[7];
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end else begin
                        cnt_q  <= div_q;
                        sclk_q <= !sclk_q;
                        edge_q <= edge_q + 4'd1;
                        if (!sclk_q) begin
                            rx_bit_q <= miso;
                        end else begin
                            sr_q <= {sr_q[6:0], rx_bit_q};
                            // Sixteenth toggle is the last falling edge of the byte.
                            if (edge_q == 4'd15) begin
                                mosi_q     <= 1'b1;
                                rx_wrreq_q <= rx_en_q;
                                state_q    <= S_DONE;
                            end else begin
                                mosi_q <= sr_q[6];
                            end
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shifter.sv
// Self-checking bench for spi_shifter: a cycle-offset reference model checks every cycle,
// a byte monitor checks hand-computed per-byte results, plus randomized traffic.
module tb_spi_shifter;

    localparam int DIV_W = 8;

    logic             clk;
    logic             reset_n;
    logic             tx_empty;
    logic [7:0]       tx_q;
    logic             tx_rdreq;
    logic             rx_full;
    logic [7:0]       rx_data;
    logic             rx_wrreq;
    logic             rx_enable;
    logic [DIV_W-1:0] div;
    logic             busy;
    logic             sclk;
    logic             mosi;
    logic             miso;

    spi_shifter #(.DIV_W(DIV_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_empty (tx_empty),
        .tx_q     (tx_q),
        .tx_rdreq (tx_rdreq),
        .rx_full  (rx_full),
        .rx_data  (rx_data),
        .rx_wrreq (rx_wrreq),
        .rx_enable(rx_enable),
        .div      (div),
        .busy     (busy),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] mosi_bits;
        int         nbits;
        int         edges;
        int         wr_count;
        int         wr_off;
        logic [7:0] wr_data;
        int         first_low;
        int         start;
    } xfer_t;

    typedef struct {
        int         dv;
        logic [7:0] tx;
        logic [7:0] slv;
        logic       en;
        logic       full;
        logic [7:0] exp_mosi;
        int         exp_wr;
        logic [7:0] exp_data;
        int         exp_off;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    logic [7:0] txq[$];
    logic [7:0] slvq[$];
    xfer_t      results[$];
    xfer_t      cur;
    bit         cur_valid = 0;
    int         rdreq_cnt = 0;
    int         rdreq_q[$];
    int         cyc = 0;
    bit         pop_pending = 0;

    bit         m_active = 0;
    int         m_start = 0;
    int         m_h = 1;
    logic       m_en = 1'b0;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_slave = 8'h00;

    logic [7:0] s_byte = 8'hFF;
    int         s_idx = 0;
    logic       prev_sclk = 1'b0;
    logic       prev_busy = 1'b0;
    int         low_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh_tx();
        tx_empty = (txq.size() == 0);
        tx_q     = (txq.size() != 0) ? txq[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] tx, input logic [7:0] slv);
        txq.push_back(tx);
        slvq.push_back(slv);
        refresh_tx();
    endtask

    task automatic set_in(input int d, input logic en, input logic full);
        @(posedge clk);
        #2;
        div       = DIV_W'(d);
        rx_enable = en;
        rx_full   = full;
    endtask

    task automatic wait_results(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (results.size() >= n) return;
        end
        check("timeout_results", results.size(), n);
    endtask

    task automatic take(output xfer_t r);
        if (results.size() > 0) r = results.pop_front();
        else r = '{default: 0};
    endtask

    // Reference model (expected outputs from the cycle offset since byte start),
    // slave device, TX FIFO pop and byte monitor; all evaluated mid-cycle.
    always @(negedge clk) begin
        logic [4:0] ev;
        int         k;
        int         h;
        cyc++;
        if (pop_pending) begin
            if (txq.size() != 0) void'(txq.pop_front());
            pop_pending = 0;
            refresh_tx();
        end

        ev = 5'b00001;
        if (!reset_n) begin
            m_active = 0;
            check("rx_data_in_reset", rx_data, 8'h00);
        end else begin
            if (m_active && (cyc - m_start) > 16 * m_h + 1) m_active = 0;
            if (!m_active) begin
                if (txq.size() != 0 && (!rx_enable || !rx_full)) begin
                    ev[4]    = 1'b1;
                    m_active = 1;
                    m_start  = cyc;
                    m_h      = int'(div) + 1;
                    m_byte   = txq[0];
                    m_en     = rx_enable;
                    m_slave  = (slvq.size() != 0) ? slvq[0] : 8'hFF;
                end
            end else begin
                k = cyc - m_start;
                if (k <= 16 * m_h) begin
                    h     = (k - 1) / m_h;
                    ev[2] = 1'b1;
                    ev[1] = h[0];
                    ev[0] = m_byte[7 - h / 2];
                end else begin
                    ev[2] = 1'b1;
                    ev[3] = m_en;
                    ev[0] = 1'b1;
                    check("rx_data_done", rx_data, m_slave);
                end
            end
        end
        check($sformatf("cycle%0d {rdreq,wrreq,busy,sclk,mosi}", cyc),
              {tx_rdreq, rx_wrreq, busy, sclk, mosi}, ev);

        if (!reset_n) begin
            miso      = 1'b1;
            cur_valid = 0;
        end else if (tx_rdreq) begin
            s_byte = (slvq.size() != 0) ? slvq.pop_front() : 8'hFF;
            s_idx  = 0;
            miso   = s_byte[7];
        end else if (prev_sclk && !sclk) begin
            s_idx++;
            if (s_idx < 8) miso = s_byte[7 - s_idx];
        end
        if (tx_rdreq) pop_pending = 1;

        if (reset_n) begin
            if (prev_busy && !busy && cur_valid) begin
                results.push_back(cur);
                cur_valid = 0;
            end
            if (tx_rdreq) begin
                cur       = '{default: 0};
                cur.start = cyc;
                cur_valid = 1;
                rdreq_cnt++;
                rdreq_q.push_back(cyc);
            end
            if (cur_valid && sclk != prev_sclk) cur.edges++;
            if (cur_valid && sclk && !prev_sclk) begin
                if (cur.nbits == 0) cur.first_low = low_run;
                cur.mosi_bits = {cur.mosi_bits[6:0], mosi};
                cur.nbits++;
            end
            if (cur_valid && rx_wrreq) begin
                cur.wr_count++;
                cur.wr_off  = cyc - cur.start;
                cur.wr_data = rx_data;
            end
        end
        low_run   = sclk ? 0 : low_run + 1;
        prev_sclk = sclk;
        prev_busy = busy;
    end

    initial begin
        vec_t  vecs[7];
        xfer_t r;
        xfer_t r1;
        int    snap;
        bit    found;

        vecs[0] = '{0, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'hA5, 1, 8'h3C, 17};
        vecs[1] = '{3, 8'h00, 8'hC3, 1'b1, 1'b0, 8'h00, 1, 8'hC3, 65};
        vecs[2] = '{3, 8'hFF, 8'h18, 1'b1, 1'b0, 8'hFF, 1, 8'h18, 65};
        vecs[3] = '{0, 8'h5A, 8'h77, 1'b0, 1'b1, 8'h5A, 0, 8'h00, 0};
        vecs[4] = '{2, 8'h81, 8'hE7, 1'b1, 1'b0, 8'h81, 1, 8'hE7, 49};
        vecs[5] = '{7, 8'h6B, 8'h2D, 1'b0, 1'b0, 8'h6B, 0, 8'h00, 0};
        vecs[6] = '{1, 8'h96, 8'h96, 1'b1, 1'b0, 8'h96, 1, 8'h96, 33};

        reset_n   = 1'b0;
        rx_full   = 1'b0;
        rx_enable = 1'b1;
        div       = '0;
        miso      = 1'b1;
        refresh_tx();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {tx_rdreq, rx_wrreq, busy, sclk, mosi}, 5'b00001);
        check("reset_rx_data", rx_data, 8'h00);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            set_in(vecs[i].dv, vecs[i].en, vecs[i].full);
            results.delete();
            push(vecs[i].tx, vecs[i].slv);
            wait_results(1, 400);
            take(r);
            check($sformatf("vec%0d_mosi", i), r.mosi_bits, vecs[i].exp_mosi);
            check($sformatf("vec%0d_nbits", i), r.nbits, 8);
            check($sformatf("vec%0d_wr_count", i), r.wr_count, vecs[i].exp_wr);
            if (vecs[i].exp_wr != 0) begin
                check($sformatf("vec%0d_rx_data", i), r.wr_data, vecs[i].exp_data);
                check($sformatf("vec%0d_wr_cycle", i), r.wr_off, vecs[i].exp_off);
            end
        end

        // Back-to-back bytes at div=3.
        set_in(3, 1'b1, 1'b0);
        results.delete();
        rdreq_q.delete();
        push(8'h00, 8'hA1);
        push(8'hFF, 8'h5E);
        wait_results(2, 400);
        take(r);
        take(r1);
        if (rdreq_q.size() >= 2) check("b2b_rdreq_spacing", rdreq_q[1] - rdreq_q[0], 66);
        else check("b2b_rdreq_count", rdreq_q.size(), 2);
        check("b2b_mosi0", r.mosi_bits, 8'h00);
        check("b2b_mosi1", r1.mosi_bits, 8'hFF);
        check("b2b_low_gap", r1.first_low, 6);
        check("b2b_rx0", r.wr_data, 8'hA1);
        check("b2b_rx1", r1.wr_data, 8'h5E);

        // RX full gates the start; dropping it starts immediately.
        set_in(0, 1'b1, 1'b1);
        results.delete();
        snap = rdreq_cnt;
        push(8'hC7, 8'h39);
        repeat (20) @(posedge clk);
        #1;
        check("gate_no_rdreq", rdreq_cnt - snap, 0);
        check("gate_idle", {busy, sclk}, 2'b00);
        #1;
        rx_full = 1'b0;
        #1;
        check("gate_release_rdreq", tx_rdreq, 1'b1);
        wait_results(1, 100);
        take(r);
        check("gate_mosi", r.mosi_bits, 8'hC7);
        check("gate_rx", r.wr_data, 8'h39);

        // Reset in the middle of a byte.
        set_in(1, 1'b1, 1'b0);
        results.delete();
        push(8'h3C, 8'h99);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (cur_valid && cur.edges >= 3) begin
                found = 1;
                break;
            end
        end
        check("rst_edges_seen", found, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_async_outputs", {tx_rdreq, rx_wrreq, busy, sclk, mosi}, 5'b00001);
        check("rst_async_rx_data", rx_data, 8'h00);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        results.delete();
        push(8'h81, 8'h42);
        wait_results(1, 200);
        take(r);
        check("post_rst_mosi", r.mosi_bits, 8'h81);
        check("post_rst_rx", r.wr_data, 8'h42);
        check("post_rst_wr_cycle", r.wr_off, 33);
        check("post_rst_wr_count", r.wr_count, 1);
        check("post_rst_fifo_empty", txq.size(), 0);

        // div change mid-byte only takes effect at the next byte.
        set_in(0, 1'b1, 1'b0);
        results.delete();
        snap = rdreq_cnt;
        push(8'hC3, 8'h5A);
        push(8'h3C, 8'hA5);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (rdreq_cnt > snap) break;
        end
        repeat (3) @(posedge clk);
        #2;
        div = DIV_W'(5);
        wait_results(2, 500);
        take(r);
        take(r1);
        check("divchg_wr0", r.wr_off, 17);
        check("divchg_wr1", r1.wr_off, 97);
        check("divchg_mosi0", r.mosi_bits, 8'hC3);
        check("divchg_mosi1", r1.mosi_bits, 8'h3C);
        check("divchg_rx1", r1.wr_data, 8'hA5);

        // Randomized traffic; the per-cycle model does the checking.
        for (int n = 0; n < 25; n++) begin
            set_in(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0));
            push(8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 50)) @(posedge clk);
        end
        @(posedge clk);
        #2;
        rx_full = 1'b0;
        found = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            if (txq.size() == 0 && !busy && !m_active) begin
                found = 1;
                break;
            end
        end
        check("random_drained", found, 1'b1);
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
